// File: rtl/ser_par_pkg.sv
// Shared definitions for the parallel-to-serial transmitter and its receiver.
package ser_par_pkg;

    // Word size shared by transmitter and receiver.
    localparam int WORD_W = 32;

    // Capture side: IDLE when no bits of a word are held, SHIFT while a partial word is held.
    typedef enum logic {
        CAP_IDLE  = 1'b0,
        CAP_SHIFT = 1'b1
    } cap_state_t;

    // Output side: EMPTY when P_OUT holds nothing, FULL while a word awaits the consumer.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/sp_shift_reg.sv
// Serial capture: MSB-first shift register and bit counter with sync realignment.
// Emits a combinational word_done pulse in the cycle the last bit of a word is
// presented, together with the completed word, so the consumer can load it on
// the same edge the counter wraps.
module sp_shift_reg
    import ser_par_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_sync,
    output logic             o_word_done,
    output logic [WIDTH-1:0] o_word,
    output logic [CNT_W-1:0] o_bit_cnt
);

    // The oldest bit of a full shift register is never observed (the completed
    // word is formed from the lower bits plus the incoming bit), so only
    // WIDTH-1 bits are stored.
    localparam int SH_W = WIDTH - 1;

    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_last_bit;
    cap_state_t       w_cap_state;

    assign w_cap_state = (r_bit_cnt == '0) ? CAP_IDLE : CAP_SHIFT;
    assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH - 1));

    // A sync bit always starts a new word, so it can never complete one.
    assign o_word_done = i_valid && !i_sync && (w_cap_state == CAP_SHIFT) && w_last_bit;
    assign o_word      = {r_shift, i_bit};
    assign o_bit_cnt   = r_bit_cnt;

    // Shift in qualified bits, realign on sync, wrap the counter at word end.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_sync) begin
            if (i_valid) begin
                r_shift   <= SH_W'(i_bit);
                r_bit_cnt <= CNT_W'(1);
            end else begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end
        end else if (i_valid) begin
            r_shift   <= o_word[SH_W-1:0];
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: assembles MSB-first serial words and presents
// them on a registered parallel output with a valid/ready handshake.
module serial_to_parallel_rx
    import ser_par_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             S_VALID,
    input  logic             S_IN,
    input  logic             S_SYNC,
    output logic [WIDTH-1:0] P_OUT,
    output logic             P_VALID,
    input  logic             P_READY,
    output logic             OVERRUN,
    output logic [CNT_W-1:0] BIT_CNT
);

    // Handshake: a word transfers on any posedge where P_VALID=1 and P_READY=1.
    // P_OUT is held stable while P_VALID=1 and the word is unaccepted; P_READY
    // is ignored while P_VALID=0. The serial side is never back-pressured, so a
    // word completing while the output is full and not being accepted is
    // dropped and recorded in the sticky OVERRUN flag.

    logic             w_word_done;
    logic [WIDTH-1:0] w_word;
    logic [CNT_W-1:0] w_bit_cnt;

    logic [WIDTH-1:0] r_p_out;
    out_state_t       r_out_state;
    logic             r_overrun;

    sp_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_valid     (S_VALID),
        .i_bit       (S_IN),
        .i_sync      (S_SYNC),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_bit_cnt   (w_bit_cnt)
    );

    // Output register FSM: load on completion when empty or being drained, else drop and flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_p_out     <= '0;
            r_out_state <= OUT_EMPTY;
            r_overrun   <= 1'b0;
        end else begin
            case (r_out_state)
                OUT_EMPTY: begin
                    if (w_word_done) begin
                        r_p_out     <= w_word;
                        r_out_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (w_word_done) begin
                        if (P_READY) begin
                            // Accept and reload on one edge: no bubble.
                            r_p_out <= w_word;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else if (P_READY) begin
                        r_out_state <= OUT_EMPTY;
                    end
                end
                default: r_out_state <= OUT_EMPTY;
            endcase
        end
    end

    assign P_OUT   = r_p_out;
    assign P_VALID = (r_out_state == OUT_FULL);
    assign OVERRUN = r_overrun;
    assign BIT_CNT = w_bit_cnt;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx with hand-computed expected words.
module tb_serial_to_parallel_rx;

    localparam int W  = 32;
    localparam int CW = $clog2(W);

    logic          CLK;
    logic          RESET;
    logic          S_VALID;
    logic          S_IN;
    logic          S_SYNC;
    logic [W-1:0]  P_OUT;
    logic          P_VALID;
    logic          P_READY;
    logic          OVERRUN;
    logic [CW-1:0] BIT_CNT;

    int n_checks = 0;
    int n_errors = 0;

    serial_to_parallel_rx #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .S_VALID (S_VALID),
        .S_IN    (S_IN),
        .S_SYNC  (S_SYNC),
        .P_OUT   (P_OUT),
        .P_VALID (P_VALID),
        .P_READY (P_READY),
        .OVERRUN (OVERRUN),
        .BIT_CNT (BIT_CNT)
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one serial bit for one clock; returns 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic sync);
        S_VALID = 1'b1;
        S_IN    = b;
        S_SYNC  = sync;
        @(posedge CLK);
        #1;
        S_VALID = 1'b0;
        S_IN    = 1'b0;
        S_SYNC  = 1'b0;
    endtask

    // Send bits hi down to lo of a word, MSB first, back to back.
    task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_p_out"},   64'(P_OUT),   64'h0);
        check_eq({tag, "_p_valid"}, 64'(P_VALID), 64'h0);
        check_eq({tag, "_overrun"}, 64'(OVERRUN), 64'h0);
        check_eq({tag, "_bit_cnt"}, 64'(BIT_CNT), 64'h0);
    endtask

    initial begin
        logic [6:0] garbage;
        RESET   = 1'b1;
        S_VALID = 1'b0;
        S_IN    = 1'b0;
        S_SYNC  = 1'b0;
        P_READY = 1'b0;
        idle(2);
        RESET = 1'b0;
        check_all_zero("reset");

        // Single word, consumer ready.
        P_READY = 1'b1;
        send_bits(32'hA5C3_0F81, 31, 1);
        check_eq("t1_not_yet_valid", 64'(P_VALID), 64'h0);
        check_eq("t1_cnt31", 64'(BIT_CNT), 64'd31);
        send_bits(32'hA5C3_0F81, 0, 0);
        check_eq("t1_valid", 64'(P_VALID), 64'h1);
        check_eq("t1_p_out", 64'(P_OUT), 64'hA5C3_0F81);
        check_eq("t1_cnt_wrap", 64'(BIT_CNT), 64'h0);
        idle(1);
        check_eq("t1_accepted", 64'(P_VALID), 64'h0);
        check_eq("t1_overrun", 64'(OVERRUN), 64'h0);

        // Same word with gaps after bit 10 and bit 20.
        send_bits(32'hA5C3_0F81, 31, 22);
        check_eq("t2_cnt10", 64'(BIT_CNT), 64'd10);
        idle(3);
        check_eq("t2_gap1_cnt", 64'(BIT_CNT), 64'd10);
        send_bits(32'hA5C3_0F81, 21, 12);
        check_eq("t2_cnt20", 64'(BIT_CNT), 64'd20);
        idle(5);
        check_eq("t2_gap2_cnt", 64'(BIT_CNT), 64'd20);
        check_eq("t2_gap_no_valid", 64'(P_VALID), 64'h0);
        send_bits(32'hA5C3_0F81, 11, 0);
        check_eq("t2_valid", 64'(P_VALID), 64'h1);
        check_eq("t2_p_out", 64'(P_OUT), 64'hA5C3_0F81);
        idle(1);
        check_eq("t2_accepted", 64'(P_VALID), 64'h0);

        // Stalled consumer: second word dropped, OVERRUN set.
        P_READY = 1'b0;
        send_bits(32'h1111_1111, 31, 0);
        check_eq("t3_w1_valid", 64'(P_VALID), 64'h1);
        check_eq("t3_w1_overrun", 64'(OVERRUN), 64'h0);
        send_bits(32'h2222_2222, 31, 0);
        check_eq("t3_p_out_held", 64'(P_OUT), 64'h1111_1111);
        check_eq("t3_overrun", 64'(OVERRUN), 64'h1);
        P_READY = 1'b1;
        idle(1);
        check_eq("t3_drained", 64'(P_VALID), 64'h0);
        check_eq("t3_overrun_sticky", 64'(OVERRUN), 64'h1);
        P_READY = 1'b0;
        do_reset();
        check_all_zero("t3_reset");

        // Accept on the same edge a new word completes.
        send_bits(32'h1111_1111, 31, 0);
        send_bits(32'h2222_2222, 31, 1);
        check_eq("t4_pending", 64'(P_OUT), 64'h1111_1111);
        P_READY = 1'b1;
        send_bits(32'h2222_2222, 0, 0);
        check_eq("t4_valid", 64'(P_VALID), 64'h1);
        check_eq("t4_p_out", 64'(P_OUT), 64'h2222_2222);
        check_eq("t4_overrun", 64'(OVERRUN), 64'h0);
        idle(1);
        check_eq("t4_accepted", 64'(P_VALID), 64'h0);

        // Sync without a valid bit clears the partial word.
        send_bits(32'hFFFF_FFFF, 4, 0);
        check_eq("t5_cnt5", 64'(BIT_CNT), 64'd5);
        S_SYNC = 1'b1;
        idle(1);
        S_SYNC = 1'b0;
        check_eq("t5_sync_novalid_cnt", 64'(BIT_CNT), 64'h0);

        // Garbage then sync with the first bit of a real word.
        garbage = 7'b1011001;
        for (int i = 6; i >= 0; i--) send_bit(garbage[i], 1'b0);
        check_eq("t5_cnt7", 64'(BIT_CNT), 64'd7);
        send_bit(1'b1, 1'b1);  // bit 31 of 0xDEADBEEF
        check_eq("t5_sync_cnt", 64'(BIT_CNT), 64'd1);
        send_bits(32'hDEAD_BEEF, 30, 0);
        check_eq("t5_valid", 64'(P_VALID), 64'h1);
        check_eq("t5_p_out", 64'(P_OUT), 64'hDEAD_BEEF);
        check_eq("t5_overrun", 64'(OVERRUN), 64'h0);
        idle(1);

        // Reset mid-word, then reset with a pending word.
        P_READY = 1'b0;
        send_bits(32'hFFFF_FFFF, 16, 0);
        check_eq("t6_cnt17", 64'(BIT_CNT), 64'd17);
        do_reset();
        check_all_zero("t6_mid_reset");
        send_bits(32'h1234_5678, 31, 0);
        check_eq("t6_pending", 64'(P_VALID), 64'h1);
        do_reset();
        check_all_zero("t6_full_reset");
        P_READY = 1'b1;
        send_bits(32'h0000_0001, 31, 0);
        check_eq("t6_clean_valid", 64'(P_VALID), 64'h1);
        check_eq("t6_clean_p_out", 64'(P_OUT), 64'h0000_0001);
        check_eq("t6_clean_overrun", 64'(OVERRUN), 64'h0);
        idle(1);
        check_eq("t6_clean_accepted", 64'(P_VALID), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
Downstream deserializer for the team's 32-bit parallel-to-serial transmitter. It samples a qualified MSB-first serial bit stream and assembles bits into WIDTH-bit words. Each completed word is presented on a registered parallel output with a valid/ready handshake, so the consumer may stall. A sync input realigns word boundaries, and a sticky flag reports words dropped because the output was stalled.

Parameters:
WIDTH, 32, word length in bits; transmitter word size; legal range 2..64
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
CLK  input  1  single clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
S_VALID  input  1  S_IN carries a valid bit this cycle
S_IN  input  1  serial data bit, MSB of word first
S_SYNC  input  1  word-boundary marker: bit sampled this cycle is bit WIDTH-1 of a new word
P_OUT  output  WIDTH  assembled word, stable while P_VALID=1
P_VALID  output  1  P_OUT holds an unconsumed word
P_READY  input  1  consumer accepts P_OUT when P_VALID=1 and P_READY=1
OVERRUN  output  1  sticky: a completed word was dropped
BIT_CNT  output  CNT_W  bits captured in current partial word (status)

Behaviour:
- Reset (posedge CLK with RESET=1) clears the following, and overrides all other inputs:
  - P_OUT=0, P_VALID=0, OVERRUN=0, BIT_CNT=0
  - shift register = 0
- Reset mid-word discards the partial word. Reset with P_VALID=1 drops the pending word, with no OVERRUN.
- Capture side, two states:
  - IDLE (BIT_CNT=0) and SHIFT (0<BIT_CNT<WIDTH).
  - On a posedge with S_VALID=1: shift register <= {shift[WIDTH-2:0], S_IN}, and BIT_CNT increments.
  - S_VALID=0: no shift and no count change. Gaps of any length are legal; the partial word is held.
  - S_SYNC=1 with S_VALID=1: the partial word is discarded, S_IN becomes the first bit (MSB), and BIT_CNT <= 1. No OVERRUN or error is raised.
  - S_SYNC=1 with S_VALID=0: BIT_CNT <= 0 and the shift register is cleared.
  - Completion: the posedge sampling the WIDTH-th valid bit returns BIT_CNT to 0 (wrap) and produces word W = {shift[WIDTH-2:0], S_IN}.
- Output side, two states: EMPTY (P_VALID=0) and FULL (P_VALID=1).
  - Completion while EMPTY: P_OUT <= W and P_VALID <= 1 on the same edge. Latency: P_OUT is valid in the cycle after the last bit is presented.
  - Accept: P_VALID=1 and P_READY=1 at a posedge clears P_VALID, unless a completion occurs on the same edge.
  - Completion on the same edge as an accept: P_OUT <= W and P_VALID stays 1. No bubble, no overrun.
  - Completion while FULL and P_READY=0: W is dropped, P_OUT is unchanged, and OVERRUN <= 1.
  - OVERRUN stays set until RESET.
  - P_READY while EMPTY is ignored.
- Capture never stalls, because the serial source cannot be back-pressured. Sustained rate: one word per WIDTH valid cycles with P_READY=1 gives zero loss.
- P_OUT changes only on a load; it is never modified while P_VALID=1 and the word is unaccepted.

Decomposition:
- Shared package ser_par_pkg holds:
  - the default WORD_W=32 used by both transmitter and receiver;
  - the capture state encoding (IDLE/SHIFT);
  - the output state encoding (EMPTY/FULL).
- One sub-module is natural: sp_shift_reg, which holds the shift register and bit counter with sync/wrap logic and emits a one-cycle word_done pulse plus word.
- The top-level holds the output register, the handshake, and OVERRUN.

Test Plan:
- Reset, 32 valid bits of 0xA5C3_0F81 MSB-first, P_READY=1 -> P_VALID=1 one cycle after the last bit, P_OUT=0xA5C3_0F81, accepted next edge, OVERRUN=0.
- Same word with S_VALID low for 3 cycles after bit 10 and 5 cycles after bit 20 -> P_OUT=0xA5C3_0F81. BIT_CNT holds 10 and 20 during the gaps.
- P_READY=0, two back-to-back words 0x1111_1111 then 0x2222_2222 -> P_OUT stays 0x1111_1111, OVERRUN=1 at the second completion. With P_READY then 1, 0x1111_1111 is accepted and P_VALID=0.
- P_READY asserted on exactly the edge word 0x2222_2222 completes, while 0x1111_1111 is pending -> P_VALID stays 1, P_OUT=0x2222_2222, OVERRUN=0.
- After 7 bits of garbage, S_SYNC=1 with the first bit of 0xDEAD_BEEF -> P_OUT=0xDEAD_BEEF after 32 bits, BIT_CNT=1 after the sync edge.
- RESET asserted at BIT_CNT=17 and again with P_VALID=1 -> all outputs 0 next cycle. A subsequent clean word 0x0000_0001 is received correctly.
